// File: rtl/branch_unit.sv
// rtl/branch_unit.sv - branch resolution in EX, 2-bit counter predictor for IF, perf counters
// Resolution results are registered; the predictor lookup is combinational with no bypass.
module branch_unit #(
  parameter int DATA_W    = 32,
  parameter int PC_W      = 32,
  parameter int BHT_DEPTH = 64,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PC_W-1:0]   if_pc,
  output logic              if_pred_taken,
  input  logic              ex_valid,
  input  logic [PC_W-1:0]   ex_pc,
  input  logic [3:0]        ALUop,
  input  logic              branch,
  input  logic              jump,
  input  logic              ex_pred_taken,
  input  logic [DATA_W-1:0] RegoutA,
  input  logic [DATA_W-1:0] RegoutB,
  output logic              PCsrc,
  output logic              res_valid,
  output logic              mispredict,
  output logic [CNT_W-1:0]  branch_cnt,
  output logic [CNT_W-1:0]  mispred_cnt
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  logic [1:0]       bht [BHT_DEPTH];
  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ex_idx;
  logic             cond;
  logic             legal;
  logic             is_br;
  logic             is_jmp;
  logic             upd;
  logic             taken;
  logic             mis;
  logic [1:0]       cur_ctr;
  logic [1:0]       nxt_ctr;

  assign if_idx        = if_pc[IDX_W+1:2];
  assign ex_idx        = ex_pc[IDX_W+1:2];
  assign if_pred_taken = bht[if_idx][1];

  always_comb begin
    cond  = 1'b0;
    legal = 1'b1;
    case (ALUop)
      4'b0001: cond = ($signed(RegoutA) == $signed(RegoutB));
      4'b0110: cond = ($signed(RegoutA) != $signed(RegoutB));
      4'b0010: cond = !RegoutA[DATA_W-1];
      4'b0101: cond = RegoutA[DATA_W-1];
      4'b0011: cond = !RegoutA[DATA_W-1] && (RegoutA != '0);
      4'b0100: cond = RegoutA[DATA_W-1] || (RegoutA == '0);
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    is_br   = ex_valid & branch;
    is_jmp  = ex_valid & jump & ~branch;
    upd     = is_br & legal;
    taken   = is_br ? (legal & cond) : is_jmp;
    mis     = upd & (cond != ex_pred_taken);
    cur_ctr = bht[ex_idx];
    nxt_ctr = cur_ctr;
    if (cond) begin
      if (cur_ctr != 2'b11) nxt_ctr = cur_ctr + 2'b01;
    end else begin
      if (cur_ctr != 2'b00) nxt_ctr = cur_ctr - 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= 2'b01;
      PCsrc       <= 1'b0;
      res_valid   <= 1'b0;
      mispredict  <= 1'b0;
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      PCsrc      <= taken;
      res_valid  <= is_br | is_jmp;
      mispredict <= mis;
      if (upd) bht[ex_idx] <= nxt_ctr;
      if (upd && (branch_cnt != '1)) branch_cnt <= branch_cnt + CNT_W'(1);
      if (mis && (mispred_cnt != '1)) mispred_cnt <= mispred_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/branch_unit.md
# branch_unit

Parametrised branch resolution and prediction unit for the MIPS pipeline. It evaluates the branch condition in EX with signed compares and registers the taken decision (`PCsrc`) plus a one-cycle `mispredict` pulse for the fetch/flush logic. It also holds a direct-mapped table of 2-bit saturating counters that supplies taken predictions to IF. It keeps saturating performance counters of resolved branches and mispredictions.

## Interface
Parameters:
- `DATA_W`, default 32: operand width; operands are two's complement.
- `PC_W`, default 32: program counter width.
- `BHT_DEPTH`, default 64: predictor entries; must be a power of 2, at least 2. `IDX_W` = log2(`BHT_DEPTH`).
- `CNT_W`, default 16: performance counter width.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst_n`, in, 1: synchronous, active-low reset.
- `if_pc`, in, `PC_W`: fetch PC to predict.
- `if_pred_taken`, out, 1: combinational prediction for `if_pc` = table[idx(`if_pc`)][1].
- `ex_valid`, in, 1: an EX-stage instruction is present this cycle.
- `ex_pc`, in, `PC_W`: PC of the EX instruction.
- `ALUop`, in, 4: branch condition select.
- `branch`, in, 1: the EX instruction is a conditional branch.
- `jump`, in, 1: the EX instruction is an unconditional jump.
- `ex_pred_taken`, in, 1: prediction made in IF for this instruction, piped down.
- `RegoutA`, in, `DATA_W`: rs operand.
- `RegoutB`, in, `DATA_W`: rt operand.
- `PCsrc`, out, 1: registered actual-taken decision.
- `res_valid`, out, 1: registered; `PCsrc`/`mispredict` are valid this cycle.
- `mispredict`, out, 1: registered one-cycle pulse; the redirect/flush is required.
- `branch_cnt`, out, `CNT_W`: resolved conditional branches, saturating.
- `mispred_cnt`, out, `CNT_W`: mispredicted conditional branches, saturating.

## Operation
- `idx(pc)` = `pc[IDX_W+1:2]`; bits [1:0] are ignored.
- Condition (A, B signed), evaluated only when `ex_valid & branch`:
  - 0001 beq: taken if A==B.
  - 0110 bne: taken if A!=B.
  - 0010 bgez: taken if A>=0.
  - 0101 bltz: taken if A<0.
  - 0011 bgtz: taken if A>0.
  - 0100 blez: taken if A<=0.
  - Any other op is "illegal": taken = 0.
- Priority: `branch` over `jump`. `ex_valid & jump & !branch` gives taken = 1, with no table update, no counting and no mispredict.
- Legal branch resolution updates counter `table[idx(ex_pc)]`:
  - Taken: increment, saturating at 11.
  - Not taken: decrement, saturating at 00.
  - Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- An illegal-op branch gives taken = 0, with no table update, no counting and no mispredict.
- `mispredict` = legal branch & (taken != `ex_pred_taken`). On mispredict, `mispred_cnt` increments unless it is saturated.
- `branch_cnt` increments on every legal branch resolution and saturates at all-ones.
- When `ex_valid` = 0: `res_valid` = 0, `PCsrc` = 0, `mispredict` = 0, and no state changes.

## Timing
- Resolution latency is 1 cycle. Inputs sampled at edge N appear on `PCsrc`/`res_valid`/`mispredict` during cycle N+1. The counter update and the perf counter increments also take effect at edge N.
- `mispredict` is high for exactly one cycle per offending branch. Back-to-back branches produce back-to-back pulses.
- `if_pred_taken` is combinational from the table and `if_pc`, with zero latency.
- Same-index update and lookup in one cycle: IF sees the pre-update value. There is no bypass; the new value is visible from cycle N+1.
- Reset (`rst_n` = 0 at an edge):
  - All table entries go to 01 (weak-NT).
  - `PCsrc`, `res_valid` and `mispredict` go to 0.
  - Both perf counters go to 0.
  - Reset asserted mid-stream overrides any concurrent resolution; that update is discarded.
- No backpressure: one resolution can be accepted every cycle.

## Test plan
- **Reset:** hold `rst_n` = 0 for 2 cycles, then sweep `if_pc` over all `BHT_DEPTH` indices -> `if_pred_taken` = 0 everywhere; all outputs and counters = 0.
- **Signed compares:** run `ALUop` 0010/0101/0011/0100 with `RegoutA` = 0xFFFFFFFF (-1), then 0, then 5 -> taken patterns are bgez 0,1,1; bltz 1,0,0; bgtz 0,0,1; blez 1,1,0. Run beq/bne with A=B=0x1234 -> beq 1, bne 0.
- **Saturation and training:** drive 3 taken beq at `ex_pc` = 0x40 -> the counter goes 01→10→11→11, and `if_pred_taken` at 0x40 becomes 1 one cycle after the first update. Then drive 2 not-taken -> the counter reaches 01 and the prediction is 0. Aliasing check: 0x40 + 4·`BHT_DEPTH` shares the entry.
- **Mispredict accounting:** 4 taken branches with `ex_pred_taken` = 0, back-to-back -> `mispredict` high for 4 consecutive cycles; `branch_cnt` = 4, `mispred_cnt` = 4. Then a jump with `ex_pred_taken` = 0 -> `PCsrc` = 1, `mispredict` = 0, counters unchanged.
- **Illegal op, branch+jump, same-index collision:**
  - Illegal op 1111 with `branch` = 1 -> `PCsrc` = 0, no update, counters unchanged.
  - `branch` and `jump` both high with bne, A=B -> `PCsrc` = 0.
  - Lookup during an update to the same index -> old prediction.
- **Reset mid-stream and counter saturation:** assert `rst_n` = 0 in the same cycle as a taken branch -> the table stays 01 and counters stay 0. With `CNT_W` = 4, drive 20 branches -> `branch_cnt` holds at 15.
